// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO responder: register offsets,
// STATUS bit positions and the FIFO count width.
package mmio_pkg;

    localparam logic [3:0] OFF_PORT   = 4'h0;
    localparam logic [3:0] OFF_TXDATA = 4'h1;
    localparam logic [3:0] OFF_STATUS = 4'h2;
    localparam logic [3:0] OFF_RELOAD = 4'h3;
    localparam logic [3:0] OFF_TCOUNT = 4'h4;

    localparam int EMPTY   = 0;
    localparam int FULL    = 1;
    localparam int CNT_LSB = 2;
    localparam int OVF     = 5;
    localparam int TFLAG   = 6;

    localparam int CNT_W = 3;

endpackage

// File: rtl/mmio_txfifo.sv
// Transmit FIFO: circular buffer, push/pop, count 0..DEPTH.
// A push while full is dropped unless a pop frees a slot that cycle.
module mmio_txfifo
    import mmio_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [7:0]       push_data,
    input  logic             pop,
    output logic [7:0]       head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             overflow_pulse
);

    localparam int AW = (DEPTH > 2) ? 2 : 1;

    logic [7:0]       r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CNT_W-1:0] r_count;

    logic          w_pop;
    logic          w_push;
    logic [AW-1:0] w_wptr_nxt;
    logic [AW-1:0] w_rptr_nxt;

    assign empty = (r_count == '0);
    assign full  = (r_count == CNT_W'(DEPTH));
    assign count = r_count;
    assign head  = r_mem[r_rptr];

    assign w_pop          = pop & ~empty;
    assign w_push         = push & (~full | w_pop);
    assign overflow_pulse = push & full & ~w_pop;

    assign w_wptr_nxt = (r_wptr == AW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
    assign w_rptr_nxt = (r_rptr == AW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= push_data;
                r_wptr        <= w_wptr_nxt;
            end
            if (w_pop) begin
                r_rptr <= w_rptr_nxt;
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

endmodule

// File: rtl/mmio_responder.sv
// MMIO responder: 16-byte window with PORT, TX FIFO, STATUS and timer.
// The reload timer is built only when MMIO_TIMER_EN is defined.
module mmio_responder
    import mmio_pkg::*;
#(
    parameter logic [7:0] BASE  = 8'hF0,
    parameter int         DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] addr,
    input  logic [7:0] data_in,
    input  logic       rden,
    input  logic       wren,
    output logic       hit,
    output logic [7:0] rd_data,
    output logic       rd_hit_q,
    output logic [7:0] port_out,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       irq
);

    logic [7:0] r_rd_data;
    logic       r_rd_hit;
    logic [7:0] r_port;
    logic       r_ovf;

    logic [3:0]       w_off;
    logic             w_wr;
    logic             w_rd;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_count;
    logic             w_full;
    logic             w_empty;
    logic             w_ovf_pulse;
    logic             w_ovf_clr;
    logic             w_tflag;
    logic [7:0]       w_status;
    logic [7:0]       w_rdata;

    assign hit   = (rden | wren) & (addr[7:4] == BASE[7:4]);
    assign w_off = addr[3:0];
    // A simultaneous store wins over the load.
    assign w_wr  = wren & hit;
    assign w_rd  = rden & ~wren & hit;

    assign w_push    = w_wr & (w_off == OFF_TXDATA);
    assign w_pop     = ~w_empty & tx_ready;
    assign w_ovf_clr = w_wr & (w_off == OFF_STATUS) & data_in[OVF];

    mmio_txfifo #(
        .DEPTH(DEPTH)
    ) u_txfifo (
        .clk           (clk),
        .rst           (rst),
        .push          (w_push),
        .push_data     (data_in),
        .pop           (w_pop),
        .head          (tx_data),
        .count         (w_count),
        .full          (w_full),
        .empty         (w_empty),
        .overflow_pulse(w_ovf_pulse)
    );

`ifdef MMIO_TIMER_EN
    logic [7:0] r_reload;
    logic [7:0] r_tcount;
    logic       r_tflag;
    logic       w_reload_wr;
    logic       w_tset;
    logic       w_tclr;

    assign w_reload_wr = w_wr & (w_off == OFF_RELOAD);
    assign w_tset = ~w_reload_wr & (r_reload != '0) & (r_tcount == '0);
    assign w_tclr = w_wr & (w_off == OFF_STATUS) & data_in[TFLAG];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reload <= '0;
            r_tcount <= '0;
            r_tflag  <= 1'b0;
        end else begin
            if (w_reload_wr) begin
                r_reload <= data_in;
                r_tcount <= data_in;
            end else if (r_reload == '0) begin
                r_tcount <= '0;
            end else if (r_tcount == '0) begin
                r_tcount <= r_reload;
            end else begin
                r_tcount <= r_tcount - 8'd1;
            end
            // Setting has priority over a same-cycle clear.
            r_tflag <= (r_tflag & ~w_tclr) | w_tset;
        end
    end

    assign w_tflag = r_tflag;
`else
    assign w_tflag = 1'b0;
`endif

    assign w_status = {1'b0, w_tflag, r_ovf, w_count, w_full, w_empty};

    always_comb begin
        w_rdata = '0;
        case (w_off)
            OFF_PORT:   w_rdata = r_port;
            OFF_STATUS: w_rdata = w_status;
`ifdef MMIO_TIMER_EN
            OFF_RELOAD: w_rdata = r_reload;
            OFF_TCOUNT: w_rdata = r_tcount;
`endif
            default:    w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_data <= '0;
            r_rd_hit  <= 1'b0;
            r_port    <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_rd_hit <= w_rd;
            if (w_rd) begin
                r_rd_data <= w_rdata;
            end
            if (w_wr && (w_off == OFF_PORT)) begin
                r_port <= data_in;
            end
            r_ovf <= (r_ovf & ~w_ovf_clr) | w_ovf_pulse;
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_hit_q = r_rd_hit;
    assign port_out = r_port;
    assign tx_valid = ~w_empty;
    assign irq      = w_tflag;

endmodule

// File: tb/tb_mmio_responder.sv
// Scoreboard bench for mmio_responder: read and TX expectations are
// queued at issue and checked by a monitor on the falling edge.
module tb_mmio_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] addr = '0;
    logic [7:0] data_in = '0;
    logic       rden = 1'b0;
    logic       wren = 1'b0;
    logic       tx_ready = 1'b0;
    logic       hit;
    logic [7:0] rd_data;
    logic       rd_hit_q;
    logic [7:0] port_out;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       irq;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] rq[$];
    logic [7:0] txq[$];

    mmio_responder #(
        .BASE (8'hF0),
        .DEPTH(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .data_in (data_in),
        .rden    (rden),
        .wren    (wren),
        .hit     (hit),
        .rd_data (rd_data),
        .rd_hit_q(rd_hit_q),
        .port_out(port_out),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [7:0] act,
                       input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (rd_hit_q) begin
                if (rq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL rd_unexpected got=%h", rd_data);
                end else begin
                    chk("rd_data", rd_data, rq.pop_front());
                end
            end
            if (tx_valid && tx_ready) begin
                if (txq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL tx_unexpected got=%h", tx_data);
                end else begin
                    chk("tx_data", tx_data, txq.pop_front());
                end
            end
        end
    end

    task automatic wr8(input logic [7:0] a, input logic [7:0] d);
        addr    = a;
        data_in = d;
        wren    = 1'b1;
        rden    = 1'b0;
        @(posedge clk);
        #1;
        wren = 1'b0;
    endtask

    task automatic rd8(input logic [7:0] a, input logic [7:0] e);
        addr = a;
        rden = 1'b1;
        wren = 1'b0;
        rq.push_back(e);
        @(posedge clk);
        #1;
        rden = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        tx_ready = 1'b1;
        while (tx_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        tx_ready = 1'b0;
        chk("drain_valid", tx_valid, 1'b0);
        chk("drain_txq", 8'(txq.size()), 8'd0);
    endtask

    logic [7:0] push_v[5];
    logic [7:0] tc_v[5];

    initial begin
        push_v = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        tc_v   = '{8'h03, 8'h02, 8'h01, 8'h00, 8'h03};

        #2;
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_rd_hit", rd_hit_q, 1'b0);
        chk("rst_port", port_out, 8'h00);
        chk("rst_valid", tx_valid, 1'b0);
        chk("rst_irq", irq, 1'b0);
        chk("rst_hit", hit, 1'b0);
        #10;
        rst = 1'b1;
        @(posedge clk);
        #1;

        wr8(8'hF0, 8'hA5);
        chk("port_out", port_out, 8'hA5);
        rd8(8'hF0, 8'hA5);
        chk("rd_hit_q", rd_hit_q, 1'b1);

        for (int i = 0; i < 5; i++) begin
            wr8(8'hF1, push_v[i]);
            if (i < 4) txq.push_back(push_v[i]);
        end
        rd8(8'hF2, 8'h32);
        wr8(8'hF2, 8'h20);
        rd8(8'hF2, 8'h12);
        drain();
        rd8(8'hF2, 8'h01);

        for (int i = 0; i < 4; i++) begin
            wr8(8'hF1, 8'hA1 + 8'(i));
            txq.push_back(8'hA1 + 8'(i));
        end
        tx_ready = 1'b1;
        wr8(8'hF1, 8'h66);
        tx_ready = 1'b0;
        txq.push_back(8'h66);
        rd8(8'hF2, 8'h12);
        drain();

        for (int i = 0; i < 3; i++) begin
            wr8(8'hF1, 8'hB1 + 8'(i));
        end
        chk("pre_rst_valid", tx_valid, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", tx_valid, 1'b0);
        chk("mid_rst_port", port_out, 8'h00);
        chk("mid_rst_rd", rd_data, 8'h00);
        chk("mid_rst_txd", tx_data, 8'h00);
        chk("mid_rst_irq", irq, 1'b0);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rd8(8'hF2, 8'h01);

`ifdef MMIO_TIMER_EN
        wr8(8'hF3, 8'h03);
        for (int i = 0; i < 5; i++) begin
            rd8(8'hF4, tc_v[i]);
            if (i == 2) chk("irq_before", irq, 1'b0);
            if (i == 3) chk("irq_set", irq, 1'b1);
        end
        rd8(8'hF3, 8'h03);
        wr8(8'hF3, 8'h00);
        wr8(8'hF2, 8'h40);
        chk("irq_clr", irq, 1'b0);
        wr8(8'hF3, 8'h01);
        wr8(8'hF2, 8'h40);
        wr8(8'hF2, 8'h40);
        chk("irq_set_wins", irq, 1'b1);
        wr8(8'hF3, 8'h00);
        wr8(8'hF2, 8'h40);
        chk("irq_clr2", irq, 1'b0);
`else
        wr8(8'hF3, 8'h03);
        rd8(8'hF3, 8'h00);
        rd8(8'hF4, 8'h00);
        repeat (6) @(posedge clk);
        #1;
        chk("irq_off", irq, 1'b0);
        wr8(8'hF2, 8'h40);
`endif
        rd8(8'hF2, 8'h01);

        rd8(8'hF7, 8'h00);
        chk("f7_hit_q", rd_hit_q, 1'b1);
        wr8(8'hF5, 8'hFF);
        wr8(8'hF0, 8'h5A);
        chk("f5_ignored", port_out, 8'h5A);
        rd8(8'hF0, 8'h5A);

        addr = 8'hEF;
        rden = 1'b1;
        #1;
        chk("ef_hit", hit, 1'b0);
        @(posedge clk);
        #1;
        rden = 1'b0;
        chk("ef_hit_q", rd_hit_q, 1'b0);
        chk("ef_rd_hold", rd_data, 8'h5A);

        addr    = 8'hF0;
        data_in = 8'h3C;
        rden    = 1'b1;
        wren    = 1'b1;
        @(posedge clk);
        #1;
        rden = 1'b0;
        wren = 1'b0;
        chk("rw_port", port_out, 8'h3C);
        chk("rw_hit_q", rd_hit_q, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("end_rq", 8'(rq.size()), 8'd0);
        chk("end_txq", 8'(txq.size()), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
